hs_upload_server: RTL and testbench
===================================

# hs_upload_server

Serves a byte window of game work RAM to the HPS over the ioctl upload channel, the read-side counterpart of the hiscore/DIP download path. It arbitrates pause with the game core, raises `ioctl_upload_req`, and answers each HPS read strobe with a RAM byte on `ioctl_din`. It also answers host-initiated uploads on its index. It sits between `hps_io` and the core's hiscore RAM port, in the `clk_sys` domain.

## Interface
- `AW`, 11: RAM address width.
- `BASE`, 0: first RAM address of the window.
- `LEN`, 64: window length in bytes, 1..2^AW.
- `INDEX`, 4: ioctl_index this block answers.
- `TIMEOUT`, 24'd4_800_000: `clk_sys` cycles to wait for `ioctl_upload` after a request.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `save_req`, in, 1: single-cycle save request.
- `paused`, in, 1: core acknowledges pause.
- `ioctl_upload`, in, 1: HPS upload in progress.
- `ioctl_rd`, in, 1: single-cycle read strobe.
- `ioctl_addr`, in, 25: byte offset within the upload.
- `ioctl_index`, in, 8: current upload index.
- `ioctl_din`, out, 8: byte returned to the HPS.
- `ioctl_upload_req`, out, 1: upload request to the HPS.
- `pause_req`, out, 1: pause request to the core.
- `ram_addr`, out, AW: RAM read address.
- `ram_rd`, out, 1: RAM read enable.
- `ram_data`, in, 8: RAM read data, fixed 1-cycle latency.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: single-cycle pulse when a serve completes.
- `err`, out, 1: single-cycle pulse on timeout.

## Operation
- FSM states: IDLE, PWAIT, REQ, SERVE, FIN.
- IDLE:
  - `save_req` -> PWAIT.
  - Rising `ioctl_upload` with `ioctl_index==INDEX` -> SERVE directly (host-initiated).
  - `save_req` in any other state is ignored.
- PWAIT: `pause_req`=1; stays until `paused`=1, then -> REQ.
- REQ:
  - `ioctl_upload_req`=1, timeout counter running.
  - Rising `ioctl_upload` with matching index -> SERVE.
  - Counter reaching TIMEOUT -> `err` pulse, go to IDLE, `pause_req` drops.
- SERVE:
  - `pause_req`=1, `ioctl_upload_req`=0.
  - Each `ioctl_rd` with matching index fetches one byte (see fetch rules).
  - Falling `ioctl_upload` -> FIN.
- FIN: `done`=1 for one cycle -> IDLE; `pause_req` deasserts in the same cycle.
- Fetch rules:
  - Offset o = `ioctl_addr[AW-1:0]`.
  - o < LEN and upper address bits zero: `ram_addr`=BASE+o, modulo 2^AW (wraps); `ram_rd`=1 for exactly one cycle.
  - Otherwise no RAM access, and `ioctl_din` loads 8'hFF.
  - An `ioctl_rd` while a fetch is pending restarts the fetch; latest wins.
  - `ioctl_rd` with a non-matching index is ignored; `ioctl_din` holds.
- `ioctl_din` holds its last value between strobes.
- Reset mid-operation: return to IDLE immediately; every output takes its reset value; any pending fetch is discarded.

## Timing
- Reset values: `ioctl_din`=8'h00. `ioctl_upload_req`, `pause_req`, `ram_rd`, `busy`, `done`, `err` = 0. `ram_addr`=0.
- Strobe in cycle T:
  - `ram_addr`/`ram_rd` registered in T+1.
  - `ram_data` sampled at the end of T+2.
  - `ioctl_din` valid in T+3.
  - Out-of-window strobe: `ioctl_din`=FF in T+1.
- HPS strobe spacing is at least 4 cycles, so back-to-back reads never collide.
- PWAIT -> REQ takes 1 cycle after `paused` is seen high.
- REQ -> SERVE takes 1 cycle after the rising `ioctl_upload` edge. The edge is detected against the registered previous value.
- Timeout counter is 24 bits, cleared on entering REQ. `err` fires in the cycle the count equals TIMEOUT.
- Same cycle as `save_req` in IDLE with a rising `ioctl_upload` of matching index: the upload wins -> SERVE.

## Test plan
- Save flow:
  - Stimulus: `save_req` pulse, `paused` raised 5 cycles later, HPS raises `ioctl_upload` (index 4) 10 cycles after `ioctl_upload_req`, then reads offsets 0..63 every 4 cycles.
  - Required: bytes match RAM[BASE..BASE+63] at T+3; `done` pulses once; `pause_req` low after FIN.
- Out of window: read at offset 64 (LEN=64) -> `ioctl_din`=FF in T+1, `ram_rd` never asserted.
- Wrap: BASE=2040, AW=11, offset 10 -> `ram_addr`=2.
- Timeout: TIMEOUT=100, HPS never responds -> `err` pulse exactly 100 cycles after entering REQ, FSM in IDLE, `pause_req`=0.
- Wrong index: `ioctl_upload` with index 3 plus strobes -> no `ram_rd`, `busy`=0, `ioctl_din` unchanged.
- Reset: assert `reset_n` low mid-SERVE with a fetch pending -> all outputs at reset values the same cycle; a later `save_req` runs a clean flow.

Source files
------------

// File: rtl/hs_upload_server.sv
// Serves a byte window of game work RAM to the HPS over the ioctl upload channel.
// Arbitrates core pause, raises the upload request and answers HPS read strobes.
module hs_upload_server #(
    parameter int unsigned AW      = 11,
    parameter int unsigned BASE    = 0,
    parameter int unsigned LEN     = 64,
    parameter logic [7:0]  INDEX   = 8'd4,
    parameter logic [23:0] TIMEOUT = 24'd4_800_000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          save_req,
    input  logic          paused,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_index,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_upload_req,
    output logic          pause_req,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PWAIT = 3'd1,
        S_REQ   = 3'd2,
        S_SERVE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_upload_d;
    logic [23:0]   r_cnt;
    logic          r_cap;

    logic          w_idx_ok;
    logic          w_up_rise;
    logic          w_up_fall;
    logic          w_start;
    logic          w_strobe;
    logic          w_in_win;
    logic [AW-1:0] w_off;

    assign w_idx_ok  = (ioctl_index == INDEX);
    assign w_up_rise = ioctl_upload & ~r_upload_d;
    assign w_up_fall = ~ioctl_upload & r_upload_d;
    assign w_start   = w_up_rise & w_idx_ok;
    assign w_strobe  = (r_state == S_SERVE) & ioctl_rd & w_idx_ok;
    assign w_off     = ioctl_addr[AW-1:0];
    // In-window only when the whole 25-bit offset lies below LEN.
    assign w_in_win  = ((ioctl_addr >> AW) == 25'd0) && (32'(w_off) < LEN);

    // Control FSM with registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_upload_d       <= 1'b0;
            r_cnt            <= 24'd0;
            ioctl_upload_req <= 1'b0;
            pause_req        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            r_upload_d <= ioctl_upload;
            done       <= 1'b0;
            err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_SERVE;
                        busy      <= 1'b1;
                        pause_req <= 1'b1;
                    end else if (save_req) begin
                        r_state   <= S_PWAIT;
                        busy      <= 1'b1;
                        pause_req <= 1'b1;
                    end
                end
                S_PWAIT: begin
                    if (paused) begin
                        r_state          <= S_REQ;
                        ioctl_upload_req <= 1'b1;
                        r_cnt            <= 24'd0;
                    end
                end
                S_REQ: begin
                    if (w_start) begin
                        r_state          <= S_SERVE;
                        ioctl_upload_req <= 1'b0;
                    end else if (r_cnt == TIMEOUT - 24'd1) begin
                        // err is visible in the cycle the count reaches TIMEOUT.
                        r_state          <= S_IDLE;
                        r_cnt            <= TIMEOUT;
                        ioctl_upload_req <= 1'b0;
                        pause_req        <= 1'b0;
                        busy             <= 1'b0;
                        err              <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_SERVE: begin
                    if (w_up_fall) begin
                        r_state   <= S_FIN;
                        pause_req <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state          <= S_IDLE;
                    ioctl_upload_req <= 1'b0;
                    pause_req        <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

    // Byte fetch pipeline: address in T+1, RAM data captured at end of T+2.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            r_cap     <= 1'b0;
            ioctl_din <= 8'h00;
        end else begin
            ram_rd <= 1'b0;
            if (w_strobe) begin
                // A new strobe cancels any capture still in flight.
                r_cap <= 1'b0;
                if (w_in_win) begin
                    ram_addr <= AW'(BASE) + w_off;
                    ram_rd   <= 1'b1;
                end else begin
                    ioctl_din <= 8'hFF;
                end
            end else begin
                r_cap <= ram_rd;
                if (r_cap) begin
                    ioctl_din <= ram_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_hs_upload_server.sv
// Directed-plus-random bench for hs_upload_server with a behavioural RAM/window model.
module tb_hs_upload_server;

    localparam int unsigned AW      = 11;
    localparam int unsigned BASE    = 2040;
    localparam int unsigned LEN     = 64;
    localparam int unsigned DEPTH   = 2048;
    localparam logic [7:0]  IDX     = 8'd4;
    localparam logic [23:0] TMO     = 24'd100;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          save_req = 1'b0;
    logic          paused = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = 25'd0;
    logic [7:0]    ioctl_index = 8'd0;
    logic [7:0]    ioctl_din;
    logic          ioctl_upload_req;
    logic          pause_req;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_data = 8'h00;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    exp_din;
    int unsigned   rd_cnt = 0;
    int unsigned   done_cnt = 0;
    int unsigned   errors = 0;
    int unsigned   checks = 0;

    hs_upload_server #(
        .AW(AW), .BASE(BASE), .LEN(LEN), .INDEX(IDX), .TIMEOUT(TMO)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_req(save_req), .paused(paused),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
        .ioctl_upload_req(ioctl_upload_req), .pause_req(pause_req),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM with one-cycle read latency, plus strobe/pulse counters.
    always @(posedge clk_sys) begin
        if (ram_rd) ram_data <= mem[ram_addr];
        if (ram_rd) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned win_addr(input int unsigned off);
        return (BASE + off) % DEPTH;
    endfunction

    // One HPS read strobe; 'serving' tells the model whether the block should answer.
    task automatic do_read(input int unsigned a, input logic [7:0] idx, input bit serving,
                           input string tag);
        int unsigned rc0;
        int unsigned exp_rd;
        rc0 = rd_cnt;
        exp_rd = 0;
        @(negedge clk_sys);
        ioctl_addr = 25'(a); ioctl_index = idx; ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        if (serving && idx == IDX && a < LEN) begin
            check({tag, "_rd"}, 32'(ram_rd), 1);
            check({tag, "_addr"}, 32'(ram_addr), win_addr(a));
            exp_din = mem[win_addr(a)];
            exp_rd = 1;
        end else if (serving && idx == IDX) begin
            check({tag, "_ff"}, 32'(ioctl_din), 32'hFF);
            exp_din = 8'hFF;
        end
        @(negedge clk_sys);
        @(negedge clk_sys);
        check({tag, "_din"}, 32'(ioctl_din), 32'(exp_din));
        check({tag, "_nrd"}, rd_cnt - rc0, exp_rd);
        @(negedge clk_sys);
    endtask

    task automatic end_serve(input string tag);
        int unsigned d0;
        d0 = done_cnt;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_pause_fin"}, 32'(pause_req), 0);
        @(negedge clk_sys);
        check({tag, "_done_off"}, 32'(done), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        paused = 1'b0;
    endtask

    // save_req -> PWAIT -> REQ; returns once upload_req is seen (bounded).
    task automatic start_save(input int unsigned pause_delay, input string tag);
        int n;
        @(negedge clk_sys);
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_pause"}, 32'(pause_req), 1);
        repeat (pause_delay) @(negedge clk_sys);
        check({tag, "_no_req_yet"}, 32'(ioctl_upload_req), 0);
        paused = 1'b1;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!ioctl_upload_req && n < 50);
        check({tag, "_req_lat"}, 32'(n), 1);
    endtask

    task automatic host_rise(input string tag);
        @(negedge clk_sys);
        ioctl_upload = 1'b1; ioctl_index = IDX;
        @(negedge clk_sys);
        check({tag, "_req_off"}, 32'(ioctl_upload_req), 0);
        check({tag, "_pause_srv"}, 32'(pause_req), 1);
        check({tag, "_busy_srv"}, 32'(busy), 1);
    endtask

    initial begin
        int k;
        int unsigned rc0;
        int unsigned off;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 254));
        exp_din = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_din", 32'(ioctl_din), 0);
        check("rst_req", 32'(ioctl_upload_req), 0);
        check("rst_pause", 32'(pause_req), 0);
        check("rst_rd", 32'(ram_rd), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        reset_n = 1'b1;

        // Save flow over the whole window, including the wrapped addresses
        start_save(5, "save");
        repeat (9) @(negedge clk_sys);
        host_rise("save");
        for (int o = 0; o < 64; o++) do_read(o, IDX, 1'b1, $sformatf("save_o%0d", o));
        check("wrap_addr", 32'(ram_addr), 32'(win_addr(63)));

        // Wrap explicit, out-of-window and wrong-index strobes inside SERVE
        do_read(10, IDX, 1'b1, "wrap10");
        check("wrap10_is2", 32'(ram_addr), 2);
        do_read(64, IDX, 1'b1, "oow64");
        do_read(3, IDX, 1'b1, "refill");
        do_read(25'h800, IDX, 1'b1, "oow_hi");
        do_read(7, IDX, 1'b1, "refill2");
        do_read(7, 8'd3, 1'b1, "badidx_srv");
        end_serve("save");

        // Timeout: HPS never answers
        start_save(2, "tmo");
        k = 0;
        while (!err && k < 150) begin
            @(negedge clk_sys);
            k++;
        end
        check("tmo_cycles", 32'(k), 100);
        check("tmo_pause", 32'(pause_req), 0);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_req", 32'(ioctl_upload_req), 0);
        @(negedge clk_sys);
        check("tmo_err_pulse", 32'(err), 0);
        paused = 1'b0;

        // Wrong index upload in IDLE
        @(negedge clk_sys);
        ioctl_upload = 1'b1; ioctl_index = 8'd3;
        @(negedge clk_sys);
        check("wi_busy", 32'(busy), 0);
        do_read(4, 8'd3, 1'b0, "wi_a");
        do_read(70, 8'd3, 1'b0, "wi_b");
        check("wi_busy2", 32'(busy), 0);
        ioctl_upload = 1'b0;

        // save_req colliding with a matching upload rise: upload wins
        @(negedge clk_sys);
        save_req = 1'b1; ioctl_upload = 1'b1; ioctl_index = IDX;
        @(negedge clk_sys);
        save_req = 1'b0;
        check("col_req", 32'(ioctl_upload_req), 0);
        check("col_pause", 32'(pause_req), 1);
        do_read(5, IDX, 1'b1, "col_rd");
        end_serve("col");

        // Host-initiated serve with random offsets
        host_rise("host");
        for (int j = 0; j < 8; j++) begin
            off = $urandom_range(0, 80);
            do_read(off, IDX, 1'b1, $sformatf("host_r%0d", j));
        end
        end_serve("host");

        // Reset mid-SERVE with a fetch pending
        host_rise("rst");
        @(negedge clk_sys);
        ioctl_addr = 25'd12; ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("rstm_pend", 32'(ram_rd), 1);
        reset_n = 1'b0;
        ioctl_upload = 1'b0;
        #1;
        check("rstm_din", 32'(ioctl_din), 0);
        check("rstm_rd", 32'(ram_rd), 0);
        check("rstm_addr", 32'(ram_addr), 0);
        check("rstm_pause", 32'(pause_req), 0);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_req", 32'(ioctl_upload_req), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        exp_din = 8'h00;
        rc0 = rd_cnt;
        repeat (3) @(negedge clk_sys);
        check("rstm_din_hold", 32'(ioctl_din), 0);
        check("rstm_no_rd", rd_cnt - rc0, 0);

        // Clean flow after reset
        start_save(3, "post");
        repeat (4) @(negedge clk_sys);
        host_rise("post");
        for (int j = 0; j < 6; j++) begin
            off = $urandom_range(0, 70);
            do_read(off, IDX, 1'b1, $sformatf("post_r%0d", j));
        end
        end_serve("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
